argmax_classifier: RTL and testbench
====================================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 SHALL have parameter N, default 8, bit width of one class score in a beat.
REQ-002 SHALL have parameter CLASS_NUM, default 10, number of classes (score channels) per beat.
REQ-003 SHALL have parameter ACC_W, default 16, signed per-class accumulator width; ACC_W >= N.
REQ-004 SHALL have parameter IDX_W, default 4, class index width; 2**IDX_W >= CLASS_NUM.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port input_vld  input  1  score beat valid (driven by last conv stage conv_dout_vld).
REQ-008 SHALL have port input_din  input  CLASS_NUM*N  class c score, signed two's complement, at bits [c*N +: N].
REQ-009 SHALL have port input_end  input  1  last beat of frame; qualified only when input_vld=1.
REQ-010 SHALL have port class_dout  output  IDX_W  winning class index.
REQ-011 SHALL have port score_dout  output  ACC_W  winning accumulated score, signed.
REQ-012 SHALL have port class_dout_vld  output  1  one-cycle strobe; class_dout/score_dout valid.
REQ-013 SHALL have port busy  output  1  high in SCAN and OUT states.
REQ-014 SHALL have port drop  output  1  sticky; set when a valid beat arrives while busy.

Function
REQ-015 SHALL implement FSM ACCUM -> SCAN -> OUT -> ACCUM; ACCUM is reset state.
REQ-016 SHALL in ACCUM, on each input_vld, add sign-extended score c into acc[c] for all c in parallel.
REQ-017 SHALL on input_vld & input_end in ACCUM, include that beat, then enter SCAN next cycle.
REQ-018 SHALL in SCAN, compare one class per cycle, index 0..CLASS_NUM-1, CLASS_NUM cycles total.
REQ-019 SHALL seed best with acc[0]/index 0; replace only when acc[c] > best (strict), so ties pick lowest index.
REQ-020 SHALL enter OUT after last compare; assert class_dout_vld for exactly one cycle in OUT.
REQ-021 SHALL have latency: end beat sampled at edge T -> class_dout_vld high in cycle after edge T+CLASS_NUM+1 (11 cycles for CLASS_NUM=10).
REQ-022 SHALL hold class_dout/score_dout stable from OUT until next OUT.
REQ-023 SHALL clear all acc[c] to 0 on OUT exit; next beat in ACCUM starts fresh frame.
REQ-024 SHALL ignore input_vld while busy (no accumulation) and set drop.
REQ-025 SHALL ignore input_end when input_vld=0.
REQ-026 SHALL treat a single-beat frame (vld & end on first beat) as a valid frame.

Reset
REQ-027 SHALL on rst_n=0 asynchronously force: state ACCUM, acc[*]=0, class_dout=0, score_dout=0, class_dout_vld=0, busy=0, drop=0.
REQ-028 SHALL abandon any in-progress frame or scan on reset with no output strobe; first result after reset comes from a complete new frame.

Configuration
REQ-029 SHALL use macro ARGMAX_SATURATE_EN to select accumulator overflow behaviour.
REQ-030 SHALL with ARGMAX_SATURATE_EN defined, clamp each acc[c] to [-2**(ACC_W-1), 2**(ACC_W-1)-1].
REQ-031 SHALL without ARGMAX_SATURATE_EN, let acc[c] wrap modulo 2**ACC_W (no clamp logic).

Verification
REQ-032 SHALL verify single beat, scores c0..c9 = {3,-1,7,2,7,0,1,-5,4,6}, end=1 -> class_dout=2, score_dout=7, vld exactly 11 cycles after end edge.
REQ-033 SHALL verify all-negative tie, all scores = -128 -> class_dout=0, score_dout=-128.
REQ-034 SHALL verify 3-beat frame, class 9 = {10,10,10}, class 4 = {29,0,0}, others 0 -> class_dout=9, score_dout=30; next frame starts with acc cleared.
REQ-035 SHALL verify vld pulse during SCAN -> drop=1, result unchanged vs. no-pulse run, drop stays 1 until reset.
REQ-036 SHALL verify 300 beats of class 1 = 127 (ACC_W=16) -> with ARGMAX_SATURATE_EN score_dout=32767; without, score_dout=38100-65536=-27436 and class_dout reflects the wrapped value.
REQ-037 SHALL verify rst_n low in SCAN cycle 5 -> no class_dout_vld; outputs 0; next full frame yields correct result.

Source files
------------

// File: rtl/argmax_classifier.sv
// Frame-level argmax: accumulates signed per-class scores over a frame, then scans for the winner.
// Optional macro ARGMAX_SATURATE_EN clamps accumulators instead of letting them wrap.
module argmax_classifier #(
   parameter int N         = 8,
   parameter int CLASS_NUM = 10,
   parameter int ACC_W     = 16,
   parameter int IDX_W     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   input_vld,
   input  logic [CLASS_NUM*N-1:0] input_din,
   input  logic                   input_end,
   output logic [IDX_W-1:0]       class_dout,
   output logic [ACC_W-1:0]       score_dout,
   output logic                   class_dout_vld,
   output logic                   busy,
   output logic                   drop
);

   typedef enum logic [1:0] {ACCUM, SCAN, OUT} state_t;

   state_t                  state;
   logic signed [ACC_W-1:0] acc      [CLASS_NUM];
   logic signed [ACC_W-1:0] acc_next [CLASS_NUM];
   logic [IDX_W-1:0]        scan_idx;
   logic [IDX_W-1:0]        best_idx;
   logic signed [ACC_W-1:0] best_score;

   for (genvar c = 0; c < CLASS_NUM; c++) begin : g_acc
      logic signed [N-1:0]     s_n;
      logic signed [ACC_W-1:0] s_x;
      assign s_n = input_din[c*N +: N];
      assign s_x = ACC_W'(s_n);
`ifdef ARGMAX_SATURATE_EN
      // One guard bit exposes overflow; its sign picks the rail to clamp to.
      logic signed [ACC_W:0] sum;
      assign sum = (ACC_W+1)'(acc[c]) + (ACC_W+1)'(s_x);
      assign acc_next[c] = (sum[ACC_W] != sum[ACC_W-1]) ?
                           (sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) :
                           sum[ACC_W-1:0];
`else
      assign acc_next[c] = acc[c] + s_x;
`endif
   end

   assign busy = (state != ACCUM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ACCUM;
         for (int unsigned c = 0; c < CLASS_NUM; c++) acc[c] <= '0;
         scan_idx       <= '0;
         best_idx       <= '0;
         best_score     <= '0;
         class_dout     <= '0;
         score_dout     <= '0;
         class_dout_vld <= 1'b0;
         drop           <= 1'b0;
      end else begin
         class_dout_vld <= 1'b0;
         case (state)
            ACCUM: begin
               if (input_vld) begin
                  for (int unsigned c = 0; c < CLASS_NUM; c++) acc[c] <= acc_next[c];
                  if (input_end) begin
                     state    <= SCAN;
                     scan_idx <= '0;
                  end
               end
            end
            SCAN: begin
               if (input_vld) drop <= 1'b1;
               // Index 0 seeds the running best; strict compare keeps the lowest index on ties.
               if (scan_idx == '0) begin
                  best_score <= acc[0];
                  best_idx   <= '0;
               end else if (acc[scan_idx] > best_score) begin
                  best_score <= acc[scan_idx];
                  best_idx   <= scan_idx;
               end
               if (scan_idx == IDX_W'(CLASS_NUM-1)) state <= OUT;
               else scan_idx <= scan_idx + 1'b1;
            end
            OUT: begin
               if (input_vld) drop <= 1'b1;
               class_dout     <= best_idx;
               score_dout     <= best_score;
               class_dout_vld <= 1'b1;
               for (int unsigned c = 0; c < CLASS_NUM; c++) acc[c] <= '0;
               state          <= ACCUM;
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: directed frames, expected results queued at the end beat.
module tb_argmax_classifier;

   localparam int N = 8, CLASS_NUM = 10, ACC_W = 16, IDX_W = 4;
   localparam int LAT = CLASS_NUM + 1;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic                   input_vld;
   logic [CLASS_NUM*N-1:0] input_din;
   logic                   input_end;
   logic [IDX_W-1:0]       class_dout;
   logic [ACC_W-1:0]       score_dout;
   logic                   class_dout_vld;
   logic                   busy;
   logic                   drop;

   argmax_classifier #(.N(N), .CLASS_NUM(CLASS_NUM), .ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst_n(rst_n), .input_vld(input_vld), .input_din(input_din),
      .input_end(input_end), .class_dout(class_dout), .score_dout(score_dout),
      .class_dout_vld(class_dout_vld), .busy(busy), .drop(drop)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [IDX_W-1:0]        idx;
      logic signed [ACC_W-1:0] score;
      int                      cyc;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   sc[CLASS_NUM];

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (class_dout_vld) begin
         if (q.size() == 0) check("unexpected_vld", 1, 0);
         else begin
            e = q.pop_front();
            check("class", class_dout, e.idx);
            check("score", $signed(score_dout), e.score);
            check("latency", cyc, e.cyc);
         end
      end
   end

   // Present sc[] as one beat; returns at #1 after the sampling edge.
   task automatic drive(input bit e);
      int t;
      for (int c = 0; c < CLASS_NUM; c++) begin
         t = sc[c];
         input_din[c*N +: N] = t[N-1:0];
      end
      input_vld = 1'b1;
      input_end = e;
      @(posedge clk); #1;
      input_vld = 1'b0;
      input_end = 1'b0;
   endtask

   task automatic frame_end(input int ei, input int es);
      exp_t e;
      drive(1'b1);
      e.idx   = ei[IDX_W-1:0];
      e.score = es[ACC_W-1:0];
      e.cyc   = cyc + LAT;
      q.push_back(e);
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while ((q.size() != 0 || busy) && n < 60);
      check("idle_timeout", (n >= 60) ? 1 : 0, 0);
   endtask

   task automatic frame_3beat();
      sc = '{default: 0}; sc[9] = 10; sc[4] = 29;
      drive(1'b0);
      sc[4] = 0;
      drive(1'b0);
      frame_end(9, 30);
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; input_vld = 1'b0; input_end = 1'b0; input_din = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_class", class_dout, 0);
      check("rst_score", score_dout, 0);
      check("rst_vld", class_dout_vld, 0);
      check("rst_busy", busy, 0);
      check("rst_drop", drop, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single beat, tie between classes 2 and 4 resolved to 2
      sc = '{3, -1, 7, 2, 7, 0, 1, -5, 4, 6};
      frame_end(2, 7);
      wait_idle();

      sc = '{default: -128};
      frame_end(0, -128);
      wait_idle();

      frame_3beat();
      // a stale class 9 total would win here if accumulators were not cleared
      sc = '{default: 0}; sc[3] = 1;
      frame_end(3, 1);
      wait_idle();

      // beat during SCAN must be dropped and flagged
      check("drop_before", drop, 0);
      sc = '{3, -1, 7, 2, 7, 0, 1, -5, 4, 6};
      frame_end(2, 7);
      repeat (3) begin @(posedge clk); #1; end
      check("busy_scan", busy, 1);
      sc = '{default: 100};
      drive(1'b0);
      wait_idle();
      check("drop_set", drop, 1);
      sc = '{default: -128};
      frame_end(0, -128);
      wait_idle();
      check("drop_sticky", drop, 1);

      // reset mid-scan: no strobe, outputs cleared, partial accumulation discarded
      sc = '{3, -1, 7, 2, 7, 0, 1, -5, 4, 6};
      drive(1'b1);
      repeat (5) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      check("midrst_class", class_dout, 0);
      check("midrst_score", score_dout, 0);
      check("midrst_vld", class_dout_vld, 0);
      check("midrst_busy", busy, 0);
      check("midrst_drop", drop, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (20) begin @(posedge clk); #1; end
      frame_3beat();

      // long frame: class 1 reaches 38100 (wraps to -27436); others end at -27648
      for (int i = 0; i < 300; i++) begin
         sc = '{default: (i < 216) ? -128 : 0};
         sc[1] = 127;
         if (i == 299) begin
`ifdef ARGMAX_SATURATE_EN
            frame_end(1, 32767);
`else
            frame_end(1, -27436);
`endif
         end else drive(1'b0);
      end
      wait_idle();
      repeat (5) begin @(posedge clk); #1; end
      check("hold_class", class_dout, 1);
`ifdef ARGMAX_SATURATE_EN
      check("hold_score", $signed(score_dout), 32767);
`else
      check("hold_score", $signed(score_dout), -27436);
`endif
      check("queue_empty", q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
